mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_req_fifo.sv | 54 +++++
 rtl/mem_bus_master.sv | 151 +++++++++++++++
 tb/tb_mem_bus_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and default sizing for the memory bus master and its request queue.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Queued command layout at default widths; the master mirrors this field order.
  typedef struct packed {
    logic                      wr_rd;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  function automatic int cmd_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request queue: power-of-2 depth, registered count, no full-bypass.
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Queued single-outstanding memory bus master with ready timeout and in-order responses.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr_rd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  sel,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_wr_rd,
  output logic                  rsp_err
);

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_cmd_t;

  localparam int CMD_W = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                r_state;
  state_t                w_next_state;
  req_cmd_t              w_push_cmd;
  req_cmd_t              w_head_cmd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_handshake;
  logic                  w_timeout;
  logic [CW-1:0]         r_wait_cnt;
  logic                  r_sel;
  logic                  r_wr_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_wr_rd;
  logic                  r_rsp_err;

  assign w_push_cmd.wr_rd = req_wr_rd;
  assign w_push_cmd.addr  = req_addr;
  assign w_push_cmd.wdata = req_wdata;
  assign w_push           = req_valid && !w_full;
  assign req_ready        = !w_full;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head_cmd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A completing handshake takes priority over a timeout on the same edge.
  assign w_handshake = r_sel && mem_ready;
  assign w_timeout   = r_sel && !mem_ready && (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_handshake || w_timeout) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The popped command loads straight into the bus registers; sel follows one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel       <= 1'b0;
      r_wr_rd     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_wr_rd <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_wr_rd    <= w_head_cmd.wr_rd;
        r_addr     <= w_head_cmd.addr;
        r_wdata    <= w_head_cmd.wdata;
        r_wait_cnt <= '0;
      end else if (r_sel && !mem_ready && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end

      if (r_state == ST_BUSY) begin
        if (w_handshake || w_timeout) begin
          r_sel       <= 1'b0;
          r_rsp_wr_rd <= r_wr_rd;
          r_rsp_err   <= !w_handshake;
          r_rsp_rdata <= (w_handshake && !r_wr_rd) ? mem_rdata : '0;
        end else begin
          r_sel <= 1'b1;
        end
      end
    end
  end

  assign sel       = r_sel;
  assign wr_rd     = r_wr_rd;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_wr_rd = r_rsp_wr_rd;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a simple memory model whose ready delay is programmable.
module tb_mem_bus_master;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr_rd = 1'b0;
  logic [7:0]  req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        sel;
  logic        wr_rd;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_wr_rd;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic        ready_en    = 1'b1;
  int          ready_delay = 0;
  int          sel_cyc     = 0;
  logic [15:0] mem [256];

  mem_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr_rd (req_wr_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .sel       (sel),
    .wr_rd     (wr_rd),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_wr_rd (rsp_wr_rd),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory model: ready after ready_delay cycles of sel, contents reset to 16'h5678.
  assign mem_rdata = mem[addr];
  assign mem_ready = sel && ready_en && (sel_cyc >= ready_delay);

  always @(posedge clk) begin
    sel_cyc <= sel ? sel_cyc + 1 : 0;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h5678;
    end else if (sel && mem_ready && wr_rd) begin
      mem[addr] <= wdata;
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d, output bit ok);
    int n;
    n = 0;
    req_wr_rd = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready === 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output bit got, output logic [15:0] d, output logic w, output logic e);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    got = (rsp_valid === 1'b1);
    d   = rsp_rdata;
    w   = rsp_wr_rd;
    e   = rsp_err;
    if (got) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic count_sel(output int c, output bit got);
    int n;
    n = 0;
    c = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      if (sel === 1'b1) c++;
      @(negedge clk);
      n++;
    end
    got = (rsp_valid === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sel, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_wr_rd, rsp_err} !== '0)
      $display("FAIL reset_outputs: got sel=%b wr_rd=%b addr=%h wdata=%h rsp_valid=%b rsp_rdata=%h rsp_wr_rd=%b rsp_err=%b want all 0",
               sel, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_wr_rd, rsp_err);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_read_after_reset();
    bit ok, got;
    logic [15:0] d;
    logic w, e;
    push_cmd(1'b0, 8'd7, 16'h0000, ok);
    n_checks++;
    if (!ok) $display("FAIL rd7_push: push not accepted");
    else n_pass++;
    n_checks++;
    if (sel !== 1'b0) $display("FAIL rd7_sel_n0: got %b want 0", sel);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (sel !== 1'b0) $display("FAIL rd7_sel_n1: got %b want 0", sel);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({sel, wr_rd, addr} !== {1'b1, 1'b0, 8'd7})
      $display("FAIL rd7_bus_n2: got sel=%b wr_rd=%b addr=%h want sel=1 wr_rd=0 addr=07", sel, wr_rd, addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, sel} !== 2'b10)
      $display("FAIL rd7_rsp_latency: got rsp_valid=%b sel=%b want rsp_valid=1 sel=0", rsp_valid, sel);
    else n_pass++;
    get_rsp(got, d, w, e);
    n_checks++;
    if (!got || {d, w, e} !== {16'h5678, 1'b0, 1'b0})
      $display("FAIL rd7_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=5678 wr_rd=0 err=0", got, d, w, e);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL rd7_single_rsp: got rsp_valid=%b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_write_read();
    bit ok1, ok2, got1, got2;
    logic [15:0] d1, d2;
    logic w1, w2, e1, e2;
    push_cmd(1'b1, 8'd2, 16'h3524, ok1);
    push_cmd(1'b0, 8'd2, 16'h0000, ok2);
    get_rsp(got1, d1, w1, e1);
    get_rsp(got2, d2, w2, e2);
    n_checks++;
    if (!(ok1 && ok2 && got1) || {d1, w1, e1} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL wr2_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=0000 wr_rd=1 err=0", got1, d1, w1, e1);
    else n_pass++;
    n_checks++;
    if (!got2 || {d2, w2, e2} !== {16'h3524, 1'b0, 1'b0})
      $display("FAIL rd2_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=3524 wr_rd=0 err=0", got2, d2, w2, e2);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sel, wr_rd, addr} !== {1'b0, 1'b0, 8'd2})
      $display("FAIL idle_hold: got sel=%b wr_rd=%b addr=%h want sel=0 wr_rd=0 addr=02", sel, wr_rd, addr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        cw [5];
    logic [7:0]  ca [5];
    logic [15:0] cd [5];
    logic [15:0] exp_d [5];
    bit ok, all_ok, got;
    logic [15:0] d;
    logic w, e;
    cw    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ca    = '{8'd10, 8'd11, 8'd10, 8'd11, 8'd12};
    cd    = '{16'hA001, 16'hA002, 16'h0000, 16'h0000, 16'hA003};
    exp_d = '{16'h0000, 16'h0000, 16'hA001, 16'hA002, 16'h0000};
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(cw[i], ca[i], cd[i], ok);
      all_ok = all_ok && ok;
    end
    n_checks++;
    if (!all_ok || req_ready !== 1'b0)
      $display("FAIL b2b_full: got pushes_ok=%b req_ready=%b want 1 and 0", all_ok, req_ready);
    else n_pass++;
    req_wr_rd = 1'b1;
    req_addr  = 8'd99;
    req_wdata = 16'hDEAD;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL b2b_still_full: got req_ready=%b want 0", req_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      get_rsp(got, d, w, e);
      n_checks++;
      if (!got || {d, w, e} !== {exp_d[i], cw[i], 1'b0})
        $display("FAIL b2b_rsp%0d: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=%h wr_rd=%b err=0",
                 i, got, d, w, e, exp_d[i], cw[i]);
      else n_pass++;
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL b2b_drained: got rsp_valid=%b req_ready=%b want 0 and 1", rsp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok1, ok2, got, got1, got2;
    int c;
    logic [15:0] d;
    logic w, e;
    ready_en = 1'b0;
    push_cmd(1'b0, 8'd5, 16'h0000, ok1);
    push_cmd(1'b0, 8'd7, 16'h0000, ok2);
    count_sel(c, got);
    n_checks++;
    if (!(ok1 && ok2 && got) || c != 15)
      $display("FAIL to_sel_cycles: got %0d (rsp seen=%b) want 15", c, got);
    else n_pass++;
    ready_en = 1'b1;
    get_rsp(got1, d, w, e);
    n_checks++;
    if (!got1 || {d, w, e} !== {16'h0000, 1'b0, 1'b1})
      $display("FAIL to_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=0000 wr_rd=0 err=1", got1, d, w, e);
    else n_pass++;
    get_rsp(got2, d, w, e);
    n_checks++;
    if (!got2 || {d, w, e} !== {16'h5678, 1'b0, 1'b0})
      $display("FAIL to_next_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=5678 wr_rd=0 err=0", got2, d, w, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    bit ok1, ok2, ok3;
    int seen;
    ready_en = 1'b0;
    push_cmd(1'b0, 8'd1, 16'h0000, ok1);
    push_cmd(1'b0, 8'd2, 16'h0000, ok2);
    push_cmd(1'b1, 8'd3, 16'h1111, ok3);
    n_checks++;
    if (!(ok1 && ok2 && ok3) || sel !== 1'b1)
      $display("FAIL rst_busy_pre: got pushes_ok=%b sel=%b want 1 and 1", ok1 && ok2 && ok3, sel);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({sel, rsp_valid} !== 2'b00)
      $display("FAIL rst_busy_async: got sel=%b rsp_valid=%b want 0 0", sel, rsp_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    ready_en = 1'b1;
    seen     = 0;
    repeat (30) begin
      @(negedge clk);
      if (sel === 1'b1 || rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || req_ready !== 1'b1)
      $display("FAIL rst_busy_discard: got active_cycles=%0d req_ready=%b want 0 and 1", seen, req_ready);
    else n_pass++;
  endtask

  task automatic test_late_ready();
    bit ok1, ok2, got, got1, got2;
    int c;
    logic [15:0] d;
    logic w, e;
    ready_delay = 0;
    push_cmd(1'b1, 8'd3, 16'hBEEF, ok1);
    get_rsp(got1, d, w, e);
    n_checks++;
    if (!(ok1 && got1) || {d, w, e} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL late_wr_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=0000 wr_rd=1 err=0", got1, d, w, e);
    else n_pass++;
    ready_delay = 14;
    push_cmd(1'b0, 8'd3, 16'h0000, ok2);
    count_sel(c, got);
    n_checks++;
    if (!(ok2 && got) || c != 15)
      $display("FAIL late_sel_cycles: got %0d (rsp seen=%b) want 15", c, got);
    else n_pass++;
    get_rsp(got2, d, w, e);
    n_checks++;
    if (!got2 || {d, w, e} !== {16'hBEEF, 1'b0, 1'b0})
      $display("FAIL late_rd_rsp: got valid=%b rdata=%h wr_rd=%b err=%b want rdata=beef wr_rd=0 err=0", got2, d, w, e);
    else n_pass++;
    ready_delay = 0;
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_late_ready();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
